// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular queue of {instr, pc, pcplus4}
// triples with valid/ready handshakes on both sides and a flush for PC redirects.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_instr,
  input  logic [DATA_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_pcplus4,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [DATA_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_pcplus4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
  } entry_t;

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  entry_t             head_s;

  // Fullness ignores out_ready, so a full queue refuses a push even while it pops.
  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign count     = count_r;
  assign push_s    = in_valid && !full_s;
  assign pop_s     = out_ready && !empty_s;

  // Head presentation: zeroed while empty so decode never sees stale storage.
  always_comb begin
    head_s = '0;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_instr   = head_s.instr;
  assign out_pc      = head_s.pc;
  assign out_pcplus4 = head_s.pcplus4;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_s) begin
      mem_r[wr_ptr_r] <= '{instr: in_instr, pc: in_pc, pcplus4: in_pcplus4};
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DATA_WIDTH=32, DEPTH=4).
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pcplus4;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic        out_ready;
  logic [2:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_pcplus4 (in_pcplus4),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_pcplus4(out_pcplus4),
    .out_ready  (out_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_in(input logic [31:0] instr, input logic [31:0] pc);
    in_instr   = instr;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(32'h0, 32'h0);

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_instr", out_instr,      32'h0000_0000);

    // Single pass
    set_in(32'h0050_0093, 32'h0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sp_out_valid",   32'(out_valid), 32'd1);
    check("sp_out_instr",   out_instr,      32'h0050_0093);
    check("sp_out_pc",      out_pc,         32'h0);
    check("sp_out_pcplus4", out_pcplus4,    32'h4);
    check("sp_count",       32'(count),     32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sp_pop_count", 32'(count),     32'd0);
    check("sp_pop_valid", 32'(out_valid), 32'd0);
    check("sp_pop_pc",    out_pc,         32'h0);

    // Fill to full, refused fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      set_in(32'h1000 + 32'(i), 32'(4 * i)); in_valid = 1'b1;
      tick();
    end
    check("fill_count",    32'(count),    32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    set_in(32'hDEAD_BEEF, 32'h10);
    tick();
    in_valid = 1'b0;
    check("fill_refuse_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc",    out_pc,    32'(4 * i));
      check("drain_instr", out_instr, 32'h1000 + 32'(i));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count),     32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      set_in(32'h2000 + 32'(i), 32'(4 * i)); in_valid = 1'b1; out_ready = 1'b1;
      tick();
      check("stream_count", 32'(count), 32'd1);
      check("stream_pc",    out_pc,     32'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      set_in(32'h3000 + 32'(i), 32'(4 * i)); in_valid = 1'b1;
      tick();
    end
    check("fpp_full_count", 32'(count), 32'd4);
    set_in(32'h3004, 32'h10); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("fpp_count",    32'(count),    32'd3);
    check("fpp_in_ready", 32'(in_ready), 32'd1);
    check("fpp_head_pc",  out_pc,        32'h4);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_count",   32'(count), 32'd3);
    check("pp_head_pc", out_pc,     32'h8);

    // Flush with concurrent push and pop
    set_in(32'h3005, 32'h14); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_pc",    out_pc,         32'h0);
    tick();
    out_ready = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);
    set_in(32'h4000_0013, 32'h40); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_flush_pc",    out_pc,     32'h40);
    check("post_flush_instr", out_instr,  32'h4000_0013);
    check("post_flush_count", 32'(count), 32'd1);

    // Reset overrides a push on a non-empty queue
    rst = 1'b1; set_in(32'h5000, 32'h50); in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst2_count", 32'(count),     32'd0);
    check("rst2_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
